// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared sizing constants for the RAM-backed FIFO controller.
package ram_fifo_ctrl_pkg;

  localparam int FIFO_DW    = 8;
  localparam int FIFO_AW    = 4;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;
  localparam int FIFO_CNT_W = FIFO_AW + 1;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Producer/consumer handshake and status bundle of the RAM FIFO controller.
interface ram_fifo_ctrl_if
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DW = FIFO_DW,
  parameter int AW = FIFO_AW
) ();

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, full, empty
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, full, empty
  );

endinterface

// File: rtl/dualport_ram.sv
// Two-port synchronous RAM; each port writes on w_x, port B returns data one cycle after add_b.
module dualport_ram
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DW = FIFO_DW,
  parameter int AW = FIFO_AW
) (
  input  logic          clk,
  input  logic          w_a,
  input  logic [AW-1:0] add_a,
  input  logic [DW-1:0] d_in_a,
  input  logic          w_b,
  input  logic [AW-1:0] add_b,
  input  logic [DW-1:0] d_in_b,
  output logic [DW-1:0] d_out_b
);

  logic [DW-1:0] mem [1 << AW];

  always_ff @(posedge clk) begin
    if (w_a) mem[add_a] <= d_in_a;
    if (w_b) mem[add_b] <= d_in_b;
    d_out_b <= mem[add_b];
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around a dual-port RAM with a two-entry head/skid output stage
// that hides the one-cycle RAM read latency and sustains one push and one pop per cycle.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DW = FIFO_DW,
  parameter int AW = FIFO_AW
) (
  input  logic          clk,
  input  logic          rst,
  ram_fifo_ctrl_if.slave bus
);

  localparam int DEPTH = 1 << AW;
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] ram_cnt_q, ram_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_pend_q, rd_pend_d;
  logic             head_vld_q, head_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic [DW-1:0]    head_q, head_d;
  logic [DW-1:0]    skid_q, skid_d;
  logic [DW-1:0]    d_out_b;

  logic             full;
  logic             push;
  logic             pop;
  logic             rd_issue;
  logic             head_free;
  logic [1:0]       occ;

  assign full = (count_q == FULL_CNT);
  assign push = bus.in_valid && !full && !rst;
  assign pop  = head_vld_q && bus.out_ready;

  // Words already committed to the output stage: held in head/skid or returning from the RAM.
  assign occ      = 2'(head_vld_q) + 2'(skid_vld_q) + 2'(rd_pend_q);
  assign rd_issue = (ram_cnt_q != '0) && ((occ < 2'd2) || ((occ == 2'd2) && pop));

  // Returning data may take the head only if it is empty once this edge's pop is applied.
  assign head_free = !head_vld_q || (pop && !skid_vld_q);

  dualport_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .w_a     (push),
    .add_a   (wr_ptr_q),
    .d_in_a  (bus.in_data),
    .w_b     (1'b0),
    .add_b   (rd_ptr_q),
    .d_in_b  ('0),
    .d_out_b (d_out_b)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    count_d    = count_q;
    rd_pend_d  = rd_issue;
    head_vld_d = head_vld_q;
    skid_vld_d = skid_vld_q;
    head_d     = head_q;
    skid_d     = skid_q;

    if (push)     wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_issue) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, rd_issue})
      2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
      2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
      default: ram_cnt_d = ram_cnt_q;
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (pop) begin
      if (skid_vld_q) begin
        head_d     = skid_q;
        head_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        head_vld_d = 1'b0;
      end
    end

    if (rd_pend_q) begin
      if (head_free) begin
        head_d     = d_out_b;
        head_vld_d = 1'b1;
      end else begin
        skid_d     = d_out_b;
        skid_vld_d = 1'b1;
      end
    end
  end

  // Control state plus the head word, which must read back as zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      count_q    <= '0;
      rd_pend_q  <= 1'b0;
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      head_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      count_q    <= count_d;
      rd_pend_q  <= rd_pend_d;
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
      head_q     <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = head_vld_q;
  assign bus.out_data  = head_q;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = (count_q == '0);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed self-checking bench for ram_fifo_ctrl.
module tb_ram_fifo_ctrl;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ram_fifo_ctrl_if #(.DW(8), .AW(4)) bus ();

  ram_fifo_ctrl #(.DW(8), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.count !== 5'd0)    begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.empty !== 1'b1)    begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hB5;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_e0_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.count !== 5'd1)     begin errors++; $display("FAIL single_count: got %0d want 1", bus.count); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_e1_valid: got %b want 0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_e2_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.out_data !== 8'hB5) begin errors++; $display("FAIL single_data: got %h want b5", bus.out_data); end
    tick();
    checks++; if (bus.count !== 5'd0)     begin errors++; $display("FAIL single_drain_count: got %0d want 0", bus.count); end
    checks++; if (bus.empty !== 1'b1)     begin errors++; $display("FAIL single_drain_empty: got %b want 1", bus.empty); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_fill();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      tick();
    end
    checks++; if (bus.full !== 1'b1)     begin errors++; $display("FAIL fill_full: got %b want 1", bus.full); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.count !== 5'd16)   begin errors++; $display("FAIL fill_count: got %0d want 16", bus.count); end
    bus.in_data = 8'h77;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.count !== 5'd16)   begin errors++; $display("FAIL fill_17th_count: got %0d want 16", bus.count); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      int n = 0;
      while (!bus.out_valid && n < 8) begin tick(); n++; end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(i)) begin
        errors++; $display("FAIL fill_drain[%0d]: got valid=%b data=%h want valid=1 data=%h", i, bus.out_valid, bus.out_data, 8'(i));
      end
      tick();
    end
    checks++; if (bus.empty !== 1'b1)    begin errors++; $display("FAIL fill_drain_empty: got %b want 1", bus.empty); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int got = 0;
    int gaps = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      bus.in_valid = (k < 40);
      bus.in_data  = 8'h20 + 8'(k);
      tick();
      if (bus.in_valid) k++;
      if (bus.out_valid) begin
        checks++;
        if (bus.out_data !== 8'h20 + 8'(got)) begin
          errors++; $display("FAIL stream_data[%0d]: got %h want %h", got, bus.out_data, 8'h20 + 8'(got));
        end
        got++;
      end else if (got > 0 && got < 40) begin
        gaps++;
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (got != 40)          begin errors++; $display("FAIL stream_words: got %0d want 40", got); end
    checks++; if (gaps != 0)          begin errors++; $display("FAIL stream_gaps: got %0d want 0", gaps); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL stream_count: got %0d want 0", bus.count); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_full_pushpop();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h30 + 8'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    checks++; if (bus.count !== 5'd16)    begin errors++; $display("FAIL fpp_pre_count: got %0d want 16", bus.count); end
    checks++; if (bus.out_data !== 8'h30) begin errors++; $display("FAIL fpp_pre_head: got %h want 30", bus.out_data); end
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hEE;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (bus.count !== 5'd15)   begin errors++; $display("FAIL fpp_count: got %0d want 15", bus.count); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fpp_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.full !== 1'b0)     begin errors++; $display("FAIL fpp_full: got %b want 0", bus.full); end
    bus.out_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      int n = 0;
      while (!bus.out_valid && n < 8) begin tick(); n++; end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h30 + 8'(i)) begin
        errors++; $display("FAIL fpp_drain[%0d]: got valid=%b data=%h want valid=1 data=%h", i, bus.out_valid, bus.out_data, 8'h30 + 8'(i));
      end
      tick();
    end
    tick();
    checks++; if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL fpp_ee_dropped: got empty=%b valid=%b data=%h want empty=1 valid=0", bus.empty, bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [19:0] pat;
    logic [7:0]  exp_w [2];
    logic [7:0]  prev_data;
    logic        prev_stall;
    int          idx;
    pat        = 20'h0A4A0;
    exp_w[0]   = 8'h5B;
    exp_w[1]   = 8'hFF;
    idx        = 0;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h5B;
    tick();
    bus.in_data   = 8'hFF;
    tick();
    bus.in_valid  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bus.out_ready = pat[c];
      if (bus.out_valid) begin
        if (prev_stall) begin
          checks++;
          if (bus.out_data !== prev_data) begin
            errors++; $display("FAIL stall_hold[%0d]: got %h want %h", c, bus.out_data, prev_data);
          end
        end
        checks++;
        if (idx > 1) begin
          errors++; $display("FAIL stall_extra[%0d]: got %h want no word", c, bus.out_data);
        end else if (bus.out_data !== exp_w[idx]) begin
          errors++; $display("FAIL stall_order[%0d]: got %h want %h", c, bus.out_data, exp_w[idx]);
        end
        if (pat[c]) idx++;
      end
      prev_stall = bus.out_valid && !pat[c];
      prev_data  = bus.out_data;
      tick();
    end
    bus.out_ready = 1'b0;
    checks++; if (idx != 2)           begin errors++; $display("FAIL stall_popped: got %0d want 2", idx); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL stall_count: got %0d want 0", bus.count); end
  endtask

  task automatic test_reset_mid();
    int n;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h60 + 8'(i);
      tick();
    end
    bus.in_valid  = 1'b0;
    tick(); tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.count !== 5'd5) begin errors++; $display("FAIL rmid_pre_count: got %0d want 5", bus.count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.count !== 5'd0)     begin errors++; $display("FAIL rmid_count: got %0d want 0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.empty !== 1'b1)     begin errors++; $display("FAIL rmid_empty: got %b want 1", bus.empty); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_stale: got valid=%b data=%h want valid=0", bus.out_valid, bus.out_data); end
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 8) begin tick(); n++; end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA1) begin
      errors++; $display("FAIL rmid_first: got valid=%b data=%h want valid=1 data=a1", bus.out_valid, bus.out_data);
    end
    tick();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rmid_final_empty: got %b want 1", bus.empty); end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_full_pushpop();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
